// File: rtl/key_filter_pkg.sv
// Shared types and default timing for the key filter bank (50 MHz clock, 20 ms debounce, 1 s long press).
package key_filter_pkg;

  localparam int CLK_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS = 20;
  localparam int LONG_MS     = 1000;

  localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int DEFAULT_LONG_CYCLES     = (CLK_HZ / 1000) * LONG_MS;

  localparam int STATE_W = 4;

  // One-hot so any corrupted encoding is trivially distinguishable from a legal one.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 4'b0001,
    ST_FILTER0 = 4'b0010,
    ST_DOWN    = 4'b0100,
    ST_FILTER1 = 4'b1000
  } filter_state_t;

endpackage

// File: rtl/key_filter_chan.sv
// One debounced key channel: 2-flop synchroniser, debounce FSM, press/release pulses and an
// optional long-press detector built when KEY_FILTER_LONG_PRESS_EN is defined.
module key_filter_chan
  import key_filter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          key_in,
  output logic          key_state,
  output logic          press_flag,
  output logic          release_flag,
  output logic          long_flag,
  output filter_state_t state
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             sync_s;
  logic [CNT_W-1:0] cnt;
  logic             press_confirm;
  logic             release_confirm;

  // Synchroniser resets high so an idle key never looks like a fresh press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_in};
    end
  end

  assign sync_s          = sync_q[1];
  assign press_confirm   = (state == ST_FILTER0) && !sync_s && (cnt == CNT_LAST);
  assign release_confirm = (state == ST_FILTER1) &&  sync_s && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      key_state    <= 1'b1;
      press_flag   <= 1'b0;
      release_flag <= 1'b0;
    end else begin
      press_flag   <= 1'b0;
      release_flag <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!sync_s) begin
            state <= ST_FILTER0;
            cnt   <= '0;
          end
        end
        ST_FILTER0: begin
          if (sync_s) begin
            state <= ST_IDLE;
          end else if (press_confirm) begin
            state      <= ST_DOWN;
            key_state  <= 1'b0;
            press_flag <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DOWN: begin
          if (sync_s) begin
            state <= ST_FILTER1;
            cnt   <= '0;
          end
        end
        ST_FILTER1: begin
          if (!sync_s) begin
            state <= ST_DOWN;
          end else if (release_confirm) begin
            state        <= ST_IDLE;
            key_state    <= 1'b1;
            release_flag <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          key_state <= 1'b1;
        end
      endcase
    end
  end

`ifdef KEY_FILTER_LONG_PRESS_EN
  localparam int HOLD_W = $clog2(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              long_done;
  logic              long_q;
  logic              holding;

  // FILTER1 keeps counting so a release bounce does not restart the hold time.
  assign holding = (state == ST_DOWN) || (state == ST_FILTER1);

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt  <= '0;
      long_done <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (press_confirm || release_confirm || !holding) begin
        hold_cnt  <= '0;
        long_done <= 1'b0;
      end else if (!long_done) begin
        if (hold_cnt == HOLD_LAST) begin
          long_q    <= 1'b1;
          long_done <= 1'b1;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end
    end
  end

  assign long_flag = long_q;
`else
  assign long_flag = 1'b0;
`endif

endmodule

// File: rtl/key_filter_bank.sv
// Bank of N_KEYS independent active-low key debouncers. Long-press pulses are built only when
// KEY_FILTER_LONG_PRESS_EN is defined; otherwise long_flag is constant 0.
module key_filter_bank
  import key_filter_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_KEYS-1:0]           key_in,
  output logic [N_KEYS-1:0]           key_state,
  output logic [N_KEYS-1:0]           press_flag,
  output logic [N_KEYS-1:0]           release_flag,
  output logic [N_KEYS-1:0]           long_flag,
  output logic [N_KEYS*STATE_W-1:0]   chan_state
);

  // chan_state packs each channel's one-hot FSM state, channel 0 in the low nibble.
  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    filter_state_t st;

    key_filter_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .key_in       (key_in[i]),
      .key_state    (key_state[i]),
      .press_flag   (press_flag[i]),
      .release_flag (release_flag[i]),
      .long_flag    (long_flag[i]),
      .state        (st)
    );

    assign chan_state[i*STATE_W +: STATE_W] = st;
  end

endmodule

// File: tb/tb_key_filter_bank.sv
// Scoreboard bench for key_filter_bank (N_KEYS=4, DEBOUNCE_CYCLES=16, LONG_CYCLES=64); checks long
// pulses when KEY_FILTER_LONG_PRESS_EN is defined and their absence otherwise.
module tb_key_filter_bank;

  localparam int N  = 4;
  localparam int D  = 16;
  localparam int L  = 64;
  localparam int W  = 48;
  // Edge 0 is the posedge after the drive; flags appear after edge D+2.
  localparam int PRESS_LAT = D + 3;

  logic         clk;
  logic         reset;
  logic [N-1:0] key_in;
  logic [N-1:0] key_state;
  logic [N-1:0] press_flag;
  logic [N-1:0] release_flag;
  logic [N-1:0] long_flag;
  logic [N*4-1:0] chan_state;

  int unsigned cyc;
  int          vectors;
  int          miscompares;
  logic [W-1:0] exp_q[$];

  key_filter_bank #(
    .N_KEYS          (N),
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_in       (key_in),
    .key_state    (key_state),
    .press_flag   (press_flag),
    .release_flag (release_flag),
    .long_flag    (long_flag),
    .chan_state   (chan_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int unsigned at, input logic [3:0] lng, input logic [3:0] rel,
                          input logic [3:0] prs, input logic [3:0] ks);
    exp_q.push_back({at, lng, rel, prs, ks});
  endtask

  task automatic check_idle(input string name, input logic [3:0] exp_ks);
    vectors++;
    if (key_state !== exp_ks || press_flag !== 4'h0 || release_flag !== 4'h0 || long_flag !== 4'h0) begin
      miscompares++;
      $display("FAIL %s: key_state=%h press=%h release=%h long=%h, required key_state=%h and no flags",
               name, key_state, press_flag, release_flag, long_flag, exp_ks);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset && (press_flag != 4'h0 || release_flag != 4'h0 || long_flag != 4'h0)) begin
      logic [W-1:0] act;
      act = {cyc, long_flag, release_flag, press_flag, key_state};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event: cycle=%0d long=%h release=%h press=%h key_state=%h, required no event",
                 cyc, long_flag, release_flag, press_flag, key_state);
      end else begin
        logic [W-1:0] exp;
        exp = exp_q.pop_front();
        if (act !== exp) begin
          miscompares++;
          $display("FAIL event: got cycle=%0d long=%h release=%h press=%h key_state=%h, required cycle=%0d long=%h release=%h press=%h key_state=%h",
                   act[47:16], act[15:12], act[11:8], act[7:4], act[3:0],
                   exp[47:16], exp[15:12], exp[11:8], exp[7:4], exp[3:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [3:0] long_exp;

  initial begin
    vectors     = 0;
    miscompares = 0;
`ifdef KEY_FILTER_LONG_PRESS_EN
    long_exp = 4'b0100;
`else
    long_exp = 4'b0000;
`endif
    reset  = 1'b1;
    key_in = 4'hF;
    step(4);
    reset = 1'b0;

    // Reset state
    check_idle("reset_outputs", 4'hF);
    vectors++;
    if (chan_state !== 16'h1111) begin
      miscompares++;
      $display("FAIL reset_state: chan_state=%h, required 1111", chan_state);
    end

    // Idle keys: no events ever
    step(40);
    check_idle("idle_high", 4'hF);

    // Single press and release on key0
    key_in = 4'hE;
    push_exp(cyc + PRESS_LAT, 4'h0, 4'h0, 4'b0001, 4'hE);
    step(30);
    check_idle("key0_held", 4'hE);
    key_in = 4'hF;
    push_exp(cyc + PRESS_LAT, 4'h0, 4'b0001, 4'h0, 4'hF);
    step(30);
    check_idle("key0_released", 4'hF);

    // key1 bounces with 5-cycle runs: never long enough to confirm
    for (int i = 0; i < 12; i++) begin
      key_in[1] = (i % 2 == 1);
      step(5);
      check_idle("key1_bounce", 4'hF);
    end
    key_in = 4'hF;
    step(30);
    check_idle("key1_settled", 4'hF);

    // key0 and key3 on the same edge
    key_in = 4'b0110;
    push_exp(cyc + PRESS_LAT, 4'h0, 4'h0, 4'b1001, 4'b0110);
    step(30);
    check_idle("keys03_held", 4'b0110);
    key_in = 4'hF;
    push_exp(cyc + PRESS_LAT, 4'h0, 4'b1001, 4'h0, 4'hF);
    step(30);

    // key2 long hold
    key_in = 4'b1011;
    push_exp(cyc + PRESS_LAT, 4'h0, 4'h0, 4'b0100, 4'b1011);
    if (long_exp != 4'h0) push_exp(cyc + PRESS_LAT + L, long_exp, 4'h0, 4'h0, 4'b1011);
    step(200);
    check_idle("key2_long_held", 4'b1011);
    key_in = 4'hF;
    push_exp(cyc + PRESS_LAT, 4'h0, 4'b0100, 4'h0, 4'hF);
    step(30);

    // Reset during FILTER0 on key1
    key_in = 4'hD;
    step(8);
    reset  = 1'b1;
    key_in = 4'hF;
    step(2);
    reset = 1'b0;
    check_idle("reset_in_filter0", 4'hF);
    vectors++;
    if (chan_state !== 16'h1111) begin
      miscompares++;
      $display("FAIL reset_filter0_state: chan_state=%h, required 1111", chan_state);
    end
    step(30);

    // Reset during DOWN on key1: no release pulse
    key_in = 4'hD;
    push_exp(cyc + PRESS_LAT, 4'h0, 4'h0, 4'b0010, 4'hD);
    step(25);
    check_idle("key1_down_before_reset", 4'hD);
    reset  = 1'b1;
    key_in = 4'hF;
    step(3);
    reset = 1'b0;
    check_idle("reset_in_down", 4'hF);
    step(30);
    check_idle("after_reset_quiet", 4'hF);

    // Re-press after reset is debounced normally
    key_in = 4'hD;
    push_exp(cyc + PRESS_LAT, 4'h0, 4'h0, 4'b0010, 4'hD);
    step(25);
    key_in = 4'hF;
    push_exp(cyc + PRESS_LAT, 4'h0, 4'b0010, 4'h0, 4'hF);
    step(30);
    check_idle("final_idle", 4'hF);

    // Any expectation left over never appeared
    while (exp_q.size() != 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_event: no event seen, required cycle=%0d long=%h release=%h press=%h key_state=%h",
               e[47:16], e[15:12], e[11:8], e[7:4], e[3:0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
